// File: rtl/vr_vc_credit_arbiter_if.sv
// ---------------------------------------------------------------------------
// vr_vc_credit_arbiter_if
// Bundles the requester-side valid/ready bus and the credit-based output link
// of vr_vc_credit_arbiter.
//
// Signals:
//   s_data_i   [N_PORTS*DATA_WIDTH] requester payloads, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_valid_i  [N_PORTS]            per-port valid
//   s_ready_o  [N_PORTS]            per-port ready (one-hot or zero)
//   m_data_o   [DATA_WIDTH]         registered payload to the link
//   m_valid_o                       one-cycle valid per transferred word
//   m_credit_i                      one-cycle pulse returning one credit
//   err_o                           sticky credit-overflow flag
//
// Modports:
//   master : the environment side (drives requests and credits)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface vr_vc_credit_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PORTS    = 4
);
    logic [N_PORTS*DATA_WIDTH-1:0] s_data_i;
    logic [N_PORTS-1:0]            s_valid_i;
    logic [N_PORTS-1:0]            s_ready_o;
    logic [DATA_WIDTH-1:0]         m_data_o;
    logic                          m_valid_o;
    logic                          m_credit_i;
    logic                          err_o;

    modport master (
        output s_data_i, s_valid_i, m_credit_i,
        input  s_ready_o, m_data_o, m_valid_o, err_o
    );

    modport slave (
        input  s_data_i, s_valid_i, m_credit_i,
        output s_ready_o, m_data_o, m_valid_o, err_o
    );
endinterface

// File: rtl/vr_vc_credit_arbiter.sv
// ---------------------------------------------------------------------------
// vr_vc_credit_arbiter
// Round-robin arbiter from N_PORTS valid/ready requesters onto a single
// credit-based link. A word is accepted only while a credit is held; the
// accepted word is presented on the link one cycle later.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : vr_vc_credit_arbiter_if.slave (requester bus, link, err flag)
//
// Parameters:
//   DATA_WIDTH : payload width per port
//   N_PORTS    : number of requesters (2..16)
//   CREDIT_NUM : receiver buffer depth = initial credit count (1..15)
//
// Configuration macro:
//   VR_VC_ARB_CREDIT_CHECK_EN : when defined, a credit returned while the
//   counter is already full sets the sticky err_o flag. When undefined,
//   err_o is tied low and such a credit is simply dropped.
// ---------------------------------------------------------------------------
module vr_vc_credit_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PORTS    = 4,
    parameter int CREDIT_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vr_vc_credit_arbiter_if.slave    bus
);
    localparam int CW = $clog2(CREDIT_NUM + 1);
    localparam int PW = $clog2(N_PORTS);

    logic [CW-1:0]         count_reg;
    logic [PW-1:0]         last_grant_reg;
    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;

    logic [PW-1:0]         cand_idx [N_PORTS];
    logic [N_PORTS-1:0]    cand_valid;
    logic [DATA_WIDTH-1:0] port_data [N_PORTS];
    logic [PW-1:0]         grant_idx;
    logic                  grant_hit;
    logic [N_PORTS-1:0]    ready;
    logic                  xfer;

    // Candidate gi is the port gi+1 places after the last grant, so the
    // candidate list is already in round-robin priority order.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cand
            assign cand_idx[gi]   = PW'((int'(last_grant_reg) + gi + 1) % N_PORTS);
            assign cand_valid[gi] = bus.s_valid_i[cand_idx[gi]];
            assign port_data[gi]  = bus.s_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Lowest-numbered valid candidate wins; scanning downward lets the last
    // hit overwrite earlier ones without a separate found flag.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = last_grant_reg;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
    end

    // Ready looks only at registered credit state, never at m_credit_i, so a
    // credit returned at zero count re-enables ready one cycle later.
    always_comb begin
        ready = '0;
        if (rst_n && (count_reg != '0) && grant_hit) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(ready & bus.s_valid_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg      <= CW'(CREDIT_NUM);
            last_grant_reg <= PW'(N_PORTS - 1);
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
        end else begin
            m_valid_reg <= xfer;
            if (xfer) begin
                m_data_reg     <= port_data[grant_idx];
                last_grant_reg <= grant_idx;
            end
            // Transfer plus credit in the same cycle cancels out; a credit at
            // full count saturates. A transfer is impossible at zero count.
            if (xfer && !bus.m_credit_i) begin
                count_reg <= count_reg - CW'(1);
            end else if (!xfer && bus.m_credit_i && (count_reg != CW'(CREDIT_NUM))) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

`ifdef VR_VC_ARB_CREDIT_CHECK_EN
    logic err_reg;
    logic overflow;

    assign overflow = !xfer && bus.m_credit_i && (count_reg == CW'(CREDIT_NUM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (overflow) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err_o = err_reg;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.s_ready_o = ready;
    assign bus.m_valid_o = m_valid_reg;
    assign bus.m_data_o  = m_data_reg;

endmodule

// File: tb/tb_vr_vc_credit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vr_vc_credit_arbiter
// Directed testbench for vr_vc_credit_arbiter (DATA_WIDTH=8, N_PORTS=4,
// CREDIT_NUM=2). A behavioural model tracks credits, the round-robin pointer
// and the output register and is compared with the DUT on every cycle;
// directed scenarios add literal expectations. Honours
// VR_VC_ARB_CREDIT_CHECK_EN for the expected err_o value.
// ---------------------------------------------------------------------------
module tb_vr_vc_credit_arbiter;
    localparam int DW = 8;
    localparam int NP = 4;
    localparam int CN = 2;

`ifdef VR_VC_ARB_CREDIT_CHECK_EN
    localparam logic EXP_OVF_ERR = 1'b1;
`else
    localparam logic EXP_OVF_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    vr_vc_credit_arbiter_if #(.DATA_WIDTH(DW), .N_PORTS(NP)) bus ();

    vr_vc_credit_arbiter #(
        .DATA_WIDTH(DW),
        .N_PORTS   (NP),
        .CREDIT_NUM(CN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] v);
        bus.s_data_i[p*DW +: DW] = v;
    endtask

    // ---------------- behavioural model ----------------
    int              m_cnt;
    int              m_last;
    logic            m_mv;
    logic [DW-1:0]   m_md;
    logic            m_err;
    bit              model_ok = 1'b0;

    // Which port must be granted: first valid port after the last grant,
    // and nobody while in reset or out of credits.
    function automatic logic [NP-1:0] rr_pick(input int last, input logic [NP-1:0] v,
                                              input int cnt, input logic rn);
        logic [NP-1:0] r;
        r = '0;
        if (rn && cnt > 0) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (last + k) % NP;
                if (v[p] && r == '0) r[p] = 1'b1;
            end
        end
        return r;
    endfunction

    initial begin
        logic [NP-1:0] er;
        int            n_cnt, n_last, g;
        logic          n_mv, n_err;
        logic [DW-1:0] n_md;
        forever begin
            @(negedge clk);
            er = rr_pick(m_last, bus.s_valid_i, m_cnt, rst_n);
            if (!model_ok) er = '0;
            check("model_ready", bus.s_ready_o, er);
            if (model_ok) begin
                check("model_m_valid", bus.m_valid_o, m_mv);
                check("model_m_data", bus.m_data_o, m_md);
                check("model_err", bus.err_o, m_err);
            end
            if (bus.m_valid_o === 1'b1)
                $display("xfer data=0x%02h t=%0t", bus.m_data_o, $time);
            // next model state from the inputs held until the coming edge
            n_cnt = m_cnt; n_last = m_last; n_mv = 1'b0; n_md = m_md; n_err = m_err;
            if (!rst_n) begin
                n_cnt = CN; n_last = NP - 1; n_md = '0; n_err = 1'b0;
            end else if (model_ok) begin
                g = -1;
                for (int p = 0; p < NP; p++) if (er[p]) g = p;
                if (g >= 0) begin
                    n_mv = 1'b1;
                    n_md = bus.s_data_i[g*DW +: DW];
                    n_last = g;
                    n_cnt = n_cnt - 1;
                end
                if (bus.m_credit_i) n_cnt = n_cnt + 1;
                if (n_cnt > CN) begin
                    n_cnt = CN;
                    if (EXP_OVF_ERR) n_err = 1'b1;
                end
            end
            @(posedge clk);
            m_cnt = n_cnt; m_last = n_last; m_mv = n_mv; m_md = n_md; m_err = n_err;
            if (!rst_n) model_ok = 1'b1;
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        bus.s_valid_i  = '0;
        bus.m_credit_i = 1'b0;
        bus.s_data_i   = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready", bus.s_ready_o, 4'b0000);
        check("rst_m_valid", bus.m_valid_o, 1'b0);
        check("rst_m_data", bus.m_data_o, 8'h00);
        check("rst_err", bus.err_o, 1'b0);
        tick(); rst_n = 1'b1;

        // single transfer from port 0
        set_data(0, 8'h11); bus.s_valid_i = 4'b0001;
        @(negedge clk); check("t033_ready", bus.s_ready_o, 4'b0001);
        tick(); bus.s_valid_i = 4'b0000;
        @(negedge clk);
        check("t033_m_valid", bus.m_valid_o, 1'b1);
        check("t033_m_data", bus.m_data_o, 8'h11);
        tick();
        @(negedge clk);
        check("t033_idle", bus.m_valid_o, 1'b0);
        check("t033_hold", bus.m_data_o, 8'h11);

        // fresh reset, then all four ports with credits returned from cycle 2
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        for (int i = 0; i < NP; i++) set_data(i, 8'hA0 + 8'(i));
        bus.s_valid_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (c % 4);
            bus.m_credit_i = (c > 0);
            @(negedge clk);
            check("t034_grant", bus.s_ready_o, eg);
            if (c > 0) begin
                check("t034_m_valid", bus.m_valid_o, 1'b1);
                check("t034_m_data", bus.m_data_o, 8'hA0 + 8'(c - 1));
            end
            tick();
        end
        bus.s_valid_i = 4'b0000; bus.m_credit_i = 1'b0;
        @(negedge clk);
        check("t034_last_m_valid", bus.m_valid_o, 1'b1);
        check("t034_last_m_data", bus.m_data_o, 8'hA0);

        // drain the last credit via port 2, then starve it
        tick(); set_data(2, 8'h22); bus.s_valid_i = 4'b0100;
        @(negedge clk); check("t035_pre", bus.s_ready_o, 4'b0100);
        tick(); set_data(2, 8'hCC);
        @(negedge clk); check("t035_empty0", bus.s_ready_o, 4'b0000);
        tick();
        @(negedge clk); check("t035_empty1", bus.s_ready_o, 4'b0000);
        tick(); bus.m_credit_i = 1'b1;
        @(negedge clk); check("t035_credit_same_cycle", bus.s_ready_o, 4'b0000);
        tick(); bus.m_credit_i = 1'b0;
        @(negedge clk);
        check("t035_regrant", bus.s_ready_o, 4'b0100);
        check("t035_no_word_yet", bus.m_valid_o, 1'b0);
        tick(); bus.s_valid_i = 4'b0000;
        @(negedge clk);
        check("t035_m_valid", bus.m_valid_o, 1'b1);
        check("t035_m_data", bus.m_data_o, 8'hCC);

        // count 0 -> 1, then transfer and credit together
        tick(); bus.m_credit_i = 1'b1;
        tick(); set_data(1, 8'h36); bus.s_valid_i = 4'b0010;
        @(negedge clk); check("t036_ready", bus.s_ready_o, 4'b0010);
        tick(); bus.m_credit_i = 1'b0;
        @(negedge clk);
        check("t036_m_valid", bus.m_valid_o, 1'b1);
        check("t036_m_data", bus.m_data_o, 8'h36);
        check("t036_count_kept", bus.s_ready_o, 4'b0010);
        tick(); bus.s_valid_i = 4'b0000;

        // refill to 2, then one extra credit (overflow)
        tick(); bus.m_credit_i = 1'b1;
        tick(); tick();
        @(negedge clk); check("t037_err_before", bus.err_o, 1'b0);
        tick(); bus.m_credit_i = 1'b0;
        @(negedge clk); check("t037_err", bus.err_o, EXP_OVF_ERR);
        tick(); bus.s_valid_i = 4'b1111;
        @(negedge clk); check("t037_grant_a", bus.s_ready_o, 4'b0100);
        tick();
        @(negedge clk); check("t037_grant_b", bus.s_ready_o, 4'b1000);
        tick();
        @(negedge clk); check("t037_saturated", bus.s_ready_o, 4'b0000);

        // reset with a pending request at zero credit; credit during reset ignored
        tick(); rst_n = 1'b0; bus.m_credit_i = 1'b1;
        @(negedge clk); check("t038_in_reset", bus.s_ready_o, 4'b0000);
        tick(); rst_n = 1'b1; bus.m_credit_i = 1'b0;
        @(negedge clk);
        check("t038_m_valid", bus.m_valid_o, 1'b0);
        check("t038_err", bus.err_o, 1'b0);
        check("t038_first", bus.s_ready_o, 4'b0001);
        tick();
        @(negedge clk); check("t038_second", bus.s_ready_o, 4'b0010);
        tick();
        @(negedge clk); check("t038_credit_ignored", bus.s_ready_o, 4'b0000);
        tick(); bus.s_valid_i = 4'b0000;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
